// File: rtl/reorder_pkg.sv
// Shared constants for the argsort engine and the downstream 9-input gather
// stage. The gather stage imports N_ELEM and IDX_W from here so both sides
// agree on window size and index width.
//   N_ELEM     : elements per window
//   IDX_W      : width of one selection index
//   LAST_PHASE : final odd-even transposition phase (N_ELEM-1)
//   ST_*       : 2-bit FSM encoding IDLE/SORT/DONE
package reorder_pkg;
  localparam int N_ELEM     = 9;
  localparam int IDX_W      = 4;
  localparam int LAST_PHASE = 8;
  localparam int PHASE_W    = 4;
  localparam int N_PAIRS    = 4;   // compare-swap cells per phase

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SORT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/reorder_cas.sv
// Single combinational compare-and-swap cell. Takes an (a, b) key/tag pair,
// where a sits at the lower network position, and returns them in rank
// order. Equal keys never swap, which keeps the whole network stable.
//   descending     : 0 = smaller key ranks first, 1 = larger key first
//   key_a/tag_a    : lower-position element
//   key_b/tag_b    : higher-position element
//   key_lo/tag_lo  : element that ends up at the lower position
//   key_hi/tag_hi  : element that ends up at the higher position
import reorder_pkg::*;

module reorder_cas #(
  parameter int DATA_W = 8
) (
  input  logic              descending,
  input  logic [DATA_W-1:0] key_a,
  input  logic [IDX_W-1:0]  tag_a,
  input  logic [DATA_W-1:0] key_b,
  input  logic [IDX_W-1:0]  tag_b,
  output logic [DATA_W-1:0] key_lo,
  output logic [IDX_W-1:0]  tag_lo,
  output logic [DATA_W-1:0] key_hi,
  output logic [IDX_W-1:0]  tag_hi
);
  logic swap;

  // Strict compare: ties fall through as "no swap".
  assign swap   = descending ? (key_a < key_b) : (key_a > key_b);
  assign key_lo = swap ? key_b : key_a;
  assign tag_lo = swap ? tag_b : tag_a;
  assign key_hi = swap ? key_a : key_b;
  assign tag_hi = swap ? tag_a : tag_b;
endmodule

// File: rtl/sort_index_gen.sv
// Sequential argsort engine. Accepts a 9-key window on a valid/ready
// handshake, sorts it with 9 phases of odd-even transposition (one phase per
// cycle, four compare-swap cells shared across even/odd phases) and presents
// index_k = original position of the k-th ranked key.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake, in_ready only in IDLE and not in reset
//   data_in0..8         : keys, position k carries original index k
//   out_valid/out_ready : output handshake, result held until accepted
//   index0..8           : ranked original positions (permutation of 0..8)
import reorder_pkg::*;

module sort_index_gen #(
  parameter int DATA_W     = 8,
  parameter bit DESCENDING = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in0,
  input  logic [DATA_W-1:0] data_in1,
  input  logic [DATA_W-1:0] data_in2,
  input  logic [DATA_W-1:0] data_in3,
  input  logic [DATA_W-1:0] data_in4,
  input  logic [DATA_W-1:0] data_in5,
  input  logic [DATA_W-1:0] data_in6,
  input  logic [DATA_W-1:0] data_in7,
  input  logic [DATA_W-1:0] data_in8,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  index0,
  output logic [IDX_W-1:0]  index1,
  output logic [IDX_W-1:0]  index2,
  output logic [IDX_W-1:0]  index3,
  output logic [IDX_W-1:0]  index4,
  output logic [IDX_W-1:0]  index5,
  output logic [IDX_W-1:0]  index6,
  output logic [IDX_W-1:0]  index7,
  output logic [IDX_W-1:0]  index8
);
  logic [1:0]         state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [DATA_W-1:0]  key_q [N_ELEM];
  logic [DATA_W-1:0]  key_d [N_ELEM];
  logic [DATA_W-1:0]  key_nx [N_ELEM];
  logic [IDX_W-1:0]   tag_q [N_ELEM];
  logic [IDX_W-1:0]   tag_d [N_ELEM];
  logic [IDX_W-1:0]   tag_nx [N_ELEM];
  logic [IDX_W-1:0]   idx_q [N_ELEM];
  logic [IDX_W-1:0]   idx_d [N_ELEM];
  logic [DATA_W-1:0]  data_in [N_ELEM];

  logic [DATA_W-1:0]  cas_ka [N_PAIRS];
  logic [DATA_W-1:0]  cas_kb [N_PAIRS];
  logic [IDX_W-1:0]   cas_ta [N_PAIRS];
  logic [IDX_W-1:0]   cas_tb [N_PAIRS];
  logic [DATA_W-1:0]  cas_klo [N_PAIRS];
  logic [DATA_W-1:0]  cas_khi [N_PAIRS];
  logic [IDX_W-1:0]   cas_tlo [N_PAIRS];
  logic [IDX_W-1:0]   cas_thi [N_PAIRS];

  assign data_in = '{data_in0, data_in1, data_in2, data_in3, data_in4,
                     data_in5, data_in6, data_in7, data_in8};

  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign out_valid = (state_q == ST_DONE);

  assign index0 = idx_q[0];
  assign index1 = idx_q[1];
  assign index2 = idx_q[2];
  assign index3 = idx_q[3];
  assign index4 = idx_q[4];
  assign index5 = idx_q[5];
  assign index6 = idx_q[6];
  assign index7 = idx_q[7];
  assign index8 = idx_q[8];

  // Even phase: cell g sorts (2g, 2g+1), element 8 bypasses.
  // Odd phase:  cell g sorts (2g+1, 2g+2), element 0 bypasses.
  for (genvar g = 0; g < N_PAIRS; g++) begin : g_cas
    assign cas_ka[g] = phase_q[0] ? key_q[2*g+1] : key_q[2*g];
    assign cas_ta[g] = phase_q[0] ? tag_q[2*g+1] : tag_q[2*g];
    assign cas_kb[g] = phase_q[0] ? key_q[2*g+2] : key_q[2*g+1];
    assign cas_tb[g] = phase_q[0] ? tag_q[2*g+2] : tag_q[2*g+1];

    reorder_cas #(.DATA_W(DATA_W)) u_cas (
      .descending (DESCENDING),
      .key_a      (cas_ka[g]),
      .tag_a      (cas_ta[g]),
      .key_b      (cas_kb[g]),
      .tag_b      (cas_tb[g]),
      .key_lo     (cas_klo[g]),
      .tag_lo     (cas_tlo[g]),
      .key_hi     (cas_khi[g]),
      .tag_hi     (cas_thi[g])
    );
  end

  // Scatter cell results back onto the element positions they came from.
  always_comb begin
    key_nx = key_q;
    tag_nx = tag_q;
    for (int g = 0; g < N_PAIRS; g++) begin
      if (phase_q[0]) begin
        key_nx[2*g+1] = cas_klo[g];
        tag_nx[2*g+1] = cas_tlo[g];
        key_nx[2*g+2] = cas_khi[g];
        tag_nx[2*g+2] = cas_thi[g];
      end else begin
        key_nx[2*g]   = cas_klo[g];
        tag_nx[2*g]   = cas_tlo[g];
        key_nx[2*g+1] = cas_khi[g];
        tag_nx[2*g+1] = cas_thi[g];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    key_d   = key_q;
    tag_d   = tag_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          key_d   = data_in;
          for (int k = 0; k < N_ELEM; k++) tag_d[k] = IDX_W'(k);
          phase_d = '0;
          state_d = ST_SORT;
        end
      end
      ST_SORT: begin
        key_d = key_nx;
        tag_d = tag_nx;
        if (phase_q == PHASE_W'(LAST_PHASE)) begin
          // Indices only ever update here, so they are stable in every
          // other state including a stalled DONE.
          idx_d   = tag_nx;
          phase_d = '0;
          state_d = ST_DONE;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      for (int k = 0; k < N_ELEM; k++) begin
        key_q[k] <= '0;
        tag_q[k] <= IDX_W'(k);
        idx_q[k] <= IDX_W'(k);
      end
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      key_q   <= key_d;
      tag_q   <= tag_d;
      idx_q   <= idx_d;
    end
  end
endmodule

// File: tb/tb_sort_index_gen.sv
module tb_sort_index_gen;
  typedef logic [7:0] win_t [9];

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, out_ready;
  logic [7:0] din [9];
  logic       rdy_a, rdy_d, ov_a, ov_d;
  logic [3:0] ia [9];
  logic [3:0] id [9];

  int n_chk = 0;
  int n_err = 0;

  localparam logic [35:0] IDENT = {4'd8,4'd7,4'd6,4'd5,4'd4,4'd3,4'd2,4'd1,4'd0};
  localparam logic [35:0] REVID = {4'd0,4'd1,4'd2,4'd3,4'd4,4'd5,4'd6,4'd7,4'd8};

  always #5 clk = ~clk;

  sort_index_gen #(.DATA_W(8), .DESCENDING(1'b0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a),
    .data_in0(din[0]), .data_in1(din[1]), .data_in2(din[2]), .data_in3(din[3]),
    .data_in4(din[4]), .data_in5(din[5]), .data_in6(din[6]), .data_in7(din[7]),
    .data_in8(din[8]), .out_valid(ov_a), .out_ready(out_ready),
    .index0(ia[0]), .index1(ia[1]), .index2(ia[2]), .index3(ia[3]), .index4(ia[4]),
    .index5(ia[5]), .index6(ia[6]), .index7(ia[7]), .index8(ia[8]));

  sort_index_gen #(.DATA_W(8), .DESCENDING(1'b1)) dut_d (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_d),
    .data_in0(din[0]), .data_in1(din[1]), .data_in2(din[2]), .data_in3(din[3]),
    .data_in4(din[4]), .data_in5(din[5]), .data_in6(din[6]), .data_in7(din[7]),
    .data_in8(din[8]), .out_valid(ov_d), .out_ready(out_ready),
    .index0(id[0]), .index1(id[1]), .index2(id[2]), .index3(id[3]), .index4(id[4]),
    .index5(id[5]), .index6(id[6]), .index7(id[7]), .index8(id[8]));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [35:0] pack(input logic [3:0] v [9]);
    logic [35:0] r;
    for (int k = 0; k < 9; k++) r[k*4 +: 4] = v[k];
    return r;
  endfunction

  // Stable argsort by ranking: element i's rank is the number of elements
  // that must precede it (strictly better key, or equal key at a lower position).
  function automatic logic [35:0] ref_idx(input win_t d, input bit desc);
    logic [35:0] r = '0;
    for (int i = 0; i < 9; i++) begin
      int rank = 0;
      for (int j = 0; j < 9; j++) begin
        bit better = desc ? (d[j] > d[i]) : (d[j] < d[i]);
        if (better || (d[j] == d[i] && j < i)) rank++;
      end
      r[rank*4 +: 4] = 4'(i);
    end
    return r;
  endfunction

  task automatic wait_ready();
    int t = 0;
    while (!rdy_a && t < 30) begin @(posedge clk); #1; t++; end
    if (!rdy_a) begin
      $display("FAIL ready_timeout got=0 exp=1");
      n_err++; n_chk++;
    end
  endtask

  // Accept one window, check latency and both result sets. Leaves the
  // DUTs in DONE (out_valid seen) without performing the handshake edge.
  task automatic send(input win_t w, output logic [35:0] ga, output logic [35:0] gd);
    int c;
    wait_ready();
    din = w;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 9; k++) din[k] = 8'($urandom);  // data need not be held
    for (c = 1; c <= 20; c++) begin
      if (ov_a) break;
      @(posedge clk); #1;
    end
    c = c - 1;
    chk("latency", 64'(c), 64'd9);
    chk("ov_match", {63'd0, ov_d}, 64'd1);
    ga = pack(ia);
    gd = pack(id);
    chk("idx_asc", 64'(ga), 64'(ref_idx(w, 1'b0)));
    chk("idx_desc", 64'(gd), 64'(ref_idx(w, 1'b1)));
  endtask

  // out_valid is currently high; take the handshake edge with out_ready=1.
  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("hs_ov", {63'd0, ov_a}, 64'd0);
    chk("hs_rdy", {62'd0, rdy_a, rdy_d}, 64'd3);
  endtask

  initial begin
    win_t w;
    logic [35:0] ga, gd;

    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 9; k++) din[k] = 8'(k);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", {62'd0, rdy_a, rdy_d}, 64'd0);
    chk("rst_ov", {62'd0, ov_a, ov_d}, 64'd0);
    chk("rst_idx_a", 64'(pack(ia)), 64'(IDENT));
    chk("rst_idx_d", 64'(pack(id)), 64'(IDENT));
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("post_rst_rdy", {62'd0, rdy_a, rdy_d}, 64'd3);

    // strictly decreasing
    w = '{8'd90, 8'd80, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10};
    send(w, ga, gd);
    chk("dec_asc_const", 64'(ga), 64'(REVID));
    chk("dec_desc_const", 64'(gd), 64'(IDENT));
    handshake();

    // all equal -> identity on both directions
    w = '{default: 8'h55};
    send(w, ga, gd);
    chk("eq_asc_const", 64'(ga), 64'(IDENT));
    chk("eq_desc_const", 64'(gd), 64'(IDENT));
    handshake();

    // ties and extremes
    w = '{8'd3, 8'd1, 8'd3, 8'd1, 8'd2, 8'hFF, 8'h00, 8'd2, 8'd1};
    send(w, ga, gd);
    chk("tie_asc_const", 64'(ga),
        64'({4'd5,4'd2,4'd0,4'd7,4'd4,4'd8,4'd3,4'd1,4'd6}));
    handshake();

    // ascending window: descending engine reverses
    w = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90};
    send(w, ga, gd);
    chk("inc_desc_const", 64'(gd), 64'(REVID));
    chk("inc_asc_const", 64'(ga), 64'(IDENT));
    handshake();

    // backpressure: stall DONE with in_valid hammering
    out_ready = 1'b0;
    w = '{8'd7, 8'd200, 8'd7, 8'd0, 8'd13, 8'd99, 8'd255, 8'd1, 8'd42};
    send(w, ga, gd);
    for (int s = 0; s < 5; s++) begin
      in_valid = 1'b1;
      for (int k = 0; k < 9; k++) din[k] = 8'($urandom);
      @(posedge clk); #1;
      chk("bp_ov", {62'd0, ov_a, ov_d}, 64'd3);
      chk("bp_rdy", {62'd0, rdy_a, rdy_d}, 64'd0);
      chk("bp_idx_a", 64'(pack(ia)), 64'(ga));
      chk("bp_idx_d", 64'(pack(id)), 64'(gd));
    end
    in_valid = 1'b0;
    handshake();
    out_ready = 1'b1;

    // reset after phase 4, with in_valid asserted alongside reset
    w = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    wait_ready();
    din = w; in_valid = 1'b1;
    @(posedge clk); #1;           // accept
    in_valid = 1'b0;
    repeat (5) @(posedge clk);    // phases 0..4
    #1;
    rst = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_ov", {62'd0, ov_a, ov_d}, 64'd0);
    chk("mid_rst_idx", 64'(pack(ia)), 64'(IDENT));
    chk("mid_rst_rdy", {62'd0, rdy_a, rdy_d}, 64'd0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("mid_rst_rdy1", {62'd0, rdy_a, rdy_d}, 64'd3);
    for (int s = 0; s < 12; s++) begin
      @(posedge clk); #1;
      chk("rst_no_accept", {62'd0, ov_a, ov_d}, 64'd0);
    end
    send(w, ga, gd);
    chk("after_rst_const", 64'(ga), 64'(REVID));
    handshake();

    // random windows, narrow key ranges sometimes to force ties
    for (int n = 0; n < 2000; n++) begin
      int m = (n % 3 == 0) ? 3 : 255;
      for (int k = 0; k < 9; k++) w[k] = 8'($urandom_range(m, 0));
      send(w, ga, gd);
      handshake();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
